sr_bank_sched: RTL and testbench

Round-robin command scheduler for a bank of SR master-slave flip-flops shared by several requesters. Each requester posts a set, reset or no-op command for one bank bit. The scheduler grants one requester at a time and drives that bit's `s`/`r` pins for exactly one clock. It then holds all pins idle while the master-slave pair propagates, and acknowledges completion. It never drives `s=r=1` into any cell.

---
 rtl/sr_bank_sched_if.sv | 16 +
 rtl/sr_bank_sched.sv | 132 +++++++++++++
 tb/tb_sr_bank_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_bank_sched_if.sv
// Requester-side bus of the SR bank scheduler: per-requester request/address/command
// in, one-hot grant/done pulses and a reject flag out.
interface sr_bank_sched_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*2-1:0]  req_cmd;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;

  modport master (output req, req_addr, req_cmd, input  gnt, done, err);
  modport slave  (input  req, req_addr, req_cmd, output gnt, done, err);
endinterface

// File: rtl/sr_bank_sched.sv
// Round-robin scheduler driving one-clock s/r pulses into a bank of SR master-slave cells.
// Optional macro SR_BANK_TOGGLE_EN: command 11 toggles the addressed cell instead of being rejected.
module sr_bank_sched #(
  parameter int NREQ     = 4,
  parameter int NBITS    = 8,
  parameter int AW       = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  sr_bank_sched_if.slave   bus,
  output logic [NBITS-1:0] s,
  output logic [NBITS-1:0] r,
  input  logic [NBITS-1:0] qs
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] CMD_RST = 2'b01;
  localparam logic [1:0] CMD_SET = 2'b10;
  localparam logic [1:0] CMD_TGL = 2'b11;

`ifdef SR_BANK_TOGGLE_EN
  localparam bit TOGGLE_EN = 1'b1;
`else
  localparam bit TOGGLE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            lat_rej;
  logic [2:0]      hold_cnt;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [AW-1:0]   pick_addr;
  logic [1:0]      pick_cmd;
  logic [NBITS-1:0] pick_sel;
  logic            pick_rej;
  logic [NBITS-1:0] pick_s;
  logic [NBITS-1:0] pick_r;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_valid && bus.req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
    pick_addr = bus.req_addr[int'(pick_idx)*AW +: AW];
    pick_cmd  = bus.req_cmd[int'(pick_idx)*2 +: 2];
  end

  // An address with no matching cell decodes to an all-zero select and is rejected.
  always_comb begin
    pick_sel = '0;
    pick_s   = '0;
    pick_r   = '0;
    for (int b = 0; b < NBITS; b++) pick_sel[b] = (pick_addr == AW'(b));
    pick_rej = (pick_sel == '0) || (pick_cmd == CMD_TGL && !TOGGLE_EN);
    if (!pick_rej) begin
      case (pick_cmd)
        CMD_SET: pick_s = pick_sel;
        CMD_RST: pick_r = pick_sel;
        CMD_TGL: if ((qs & pick_sel) != '0) pick_r = pick_sel; else pick_s = pick_sel;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      winner   <= '0;
      lat_rej  <= 1'b0;
      hold_cnt <= '0;
      bus.gnt  <= '0;
      bus.done <= '0;
      bus.err  <= 1'b0;
      s        <= '0;
      r        <= '0;
    end else begin
      // NOTE: all registered state uses non-blocking assignment so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner  <= pick_idx;
            lat_rej <= pick_rej;
            bus.gnt <= NREQ'(1) << pick_idx;
            s       <= pick_s;
            r       <= pick_r;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          bus.gnt  <= '0;
          s        <= '0;
          r        <= '0;
          ptr      <= (int'(winner) == NREQ - 1) ? '0 : winner + PW'(1);
          hold_cnt <= 3'd1;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == 3'(HOLD_CYC)) begin
            bus.done <= NREQ'(1) << winner;
            bus.err  <= lat_rej;
            state    <= DONE;
          end else begin
            hold_cnt <= hold_cnt + 3'd1;
          end
        end
        DONE: begin
          bus.done <= '0;
          bus.err  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_bank_sched.sv
// Bench for sr_bank_sched: directed scenarios plus a random run, all checked cycle by cycle
// against a transaction-timeline model of the scheduler.
module tb_sr_bank_sched;
  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int AW    = 3;
  localparam int HOLD  = 1;
`ifdef SR_BANK_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NBITS-1:0] s, r, qs;

  sr_bank_sched_if #(.NREQ(NREQ), .AW(AW)) bus ();

  sr_bank_sched #(.NREQ(NREQ), .NBITS(NBITS), .AW(AW), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .s(s), .r(r), .qs(qs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Requester-side stimulus
  logic [NREQ-1:0] req_v;
  logic [AW-1:0]   addr_a [NREQ];
  logic [1:0]      cmd_a  [NREQ];
  bit              busy   [NREQ];

  // Timeline model: a decision at edge n shows grant after n, done after n+1+HOLD, next decision at n+HOLD+3.
  int edge_n = 0, next_dec = 0, g_edge = 0, d_edge = 0, m_ptr = 0, m_w = 0;
  bit pend = 0, m_rej = 0;
  logic [AW-1:0]    m_addr;
  logic [1:0]       m_cmd;
  logic [NBITS-1:0] m_s, m_r, exp_s, exp_r;
  logic [NREQ-1:0]  exp_gnt, exp_done;
  logic             exp_err;

  logic [NBITS-1:0] saw_s, saw_r;
  logic             saw_err;
  bit               rec_en = 0;
  int               gnt_seen[$];

  task automatic push_inputs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                 = req_v[i];
      bus.req_addr[i*AW +: AW]   = addr_a[i];
      bus.req_cmd[i*2 +: 2]      = cmd_a[i];
    end
  endtask

  task automatic model_edge();
    exp_gnt = '0; exp_done = '0; exp_err = 1'b0; exp_s = '0; exp_r = '0;
    if (!rst) return;
    if (!pend && edge_n >= next_dec && req_v != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int i = (m_ptr + k) % NREQ;
        if (req_v[i]) begin m_w = i; break; end
      end
      m_addr = addr_a[m_w];
      m_cmd  = cmd_a[m_w];
      m_rej  = (int'(m_addr) >= NBITS) || (m_cmd == 2'b11 && !TOGGLE);
      m_s = '0; m_r = '0;
      if (!m_rej) begin
        if (m_cmd == 2'b10) m_s[m_addr] = 1'b1;
        else if (m_cmd == 2'b01) m_r[m_addr] = 1'b1;
        else if (m_cmd == 2'b11) begin
          if (qs[m_addr]) m_r[m_addr] = 1'b1; else m_s[m_addr] = 1'b1;
        end
      end
      g_edge   = edge_n;
      d_edge   = edge_n + 1 + HOLD;
      next_dec = edge_n + HOLD + 3;
      m_ptr    = (m_w + 1) % NREQ;
      pend     = 1'b1;
    end
    if (pend && edge_n == g_edge) begin
      exp_gnt[m_w] = 1'b1; exp_s = m_s; exp_r = m_r;
    end
    if (pend && edge_n == d_edge) begin
      exp_done[m_w] = 1'b1; exp_err = m_rej; pend = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    check("gnt", bus.gnt, exp_gnt);
    check("done", bus.done, exp_done);
    check("err", bus.err, exp_err);
    check("s", s, exp_s);
    check("r", r, exp_r);
    check("s_and_r", s & r, 0);
    check("onehot_sr", 32'($countones(s | r) <= 1), 1);
    if (rec_en && bus.gnt != '0)
      for (int j = 0; j < NREQ; j++) if (bus.gnt[j]) gnt_seen.push_back(j);
    saw_s |= s; saw_r |= r; saw_err |= bus.err;
    for (int i = 0; i < NREQ; i++)
      if (exp_done[i]) begin req_v[i] = 1'b0; busy[i] = 1'b0; end
    push_inputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_sr", s | r, 0);
    pend = 1'b0; m_ptr = 0; next_dec = 0;
    for (int i = 0; i < NREQ; i++) busy[i] = req_v[i];
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic run_until_quiet(input int max);
    int n = 0;
    while ((pend || req_v != '0) && n < max) begin step(); n++; end
    check("drain", 32'(pend || req_v != '0), 0);
  endtask

  task automatic raise(input int i, input logic [AW-1:0] a, input logic [1:0] c);
    req_v[i] = 1'b1; busy[i] = 1'b1; addr_a[i] = a; cmd_a[i] = c;
    push_inputs();
  endtask

  function automatic int seen(input int k);
    return (k < gnt_seen.size()) ? gnt_seen[k] : -1;
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (req_v[i] && pend && m_w == i && $urandom_range(7) == 0) req_v[i] = 1'b0;
      else if (!busy[i] && $urandom_range(3) == 0)
        raise(i, AW'($urandom_range(7)), 2'($urandom_range(3)));
    end
    qs = NBITS'($urandom);
    push_inputs();
  endtask

  initial begin
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin addr_a[i] = '0; cmd_a[i] = '0; busy[i] = 1'b0; end
    qs = 6'b100000;
    saw_s = '0; saw_r = '0; saw_err = 1'b0;
    push_inputs();
    do_reset(2);

    // Single set request: grant and s[3] one cycle after sampling, done two cycles later.
    raise(0, 3'd3, 2'b10);
    step();
    check("plan_gnt", bus.gnt, 4'b0001);
    check("plan_s3", s, 6'b001000);
    step();
    check("plan_hold", s | r | bus.gnt, 0);
    step();
    check("plan_done", bus.done, 4'b0001);
    check("plan_err", bus.err, 0);
    run_until_quiet(20);

    // Round robin with all four held and re-raised after each done.
    do_reset(2);
    for (int i = 0; i < NREQ; i++) raise(i, AW'(i + 1), 2'b01);
    gnt_seen.delete();
    rec_en = 1'b1;
    for (int n = 0; n < 60 && gnt_seen.size() < 5; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (!busy[i]) raise(i, AW'(i + 1), 2'b01);
    end
    rec_en = 1'b0;
    check("rr_count", 32'(gnt_seen.size() >= 5), 1);
    check("rr_0", seen(0), 0);
    check("rr_1", seen(1), 1);
    check("rr_2", seen(2), 2);
    check("rr_3", seen(3), 3);
    check("rr_4", seen(4), 0);
    run_until_quiet(40);

    // Command 11 at addr 5 with qs[5]=1: toggle resets the cell, otherwise rejected.
    saw_s = '0; saw_r = '0; saw_err = 1'b0;
    raise(2, 3'd5, 2'b11);
    run_until_quiet(20);
    check("tgl_err", saw_err, TOGGLE ? 0 : 1);
    check("tgl_r", saw_r, TOGGLE ? 6'b100000 : 6'b000000);
    check("tgl_s", saw_s, 0);

    // Address beyond the bank.
    saw_s = '0; saw_r = '0; saw_err = 1'b0;
    raise(1, 3'd7, 2'b10);
    run_until_quiet(20);
    check("oor_err", saw_err, 1);
    check("oor_sr", saw_s | saw_r, 0);

    // Reset during HOLD: no done, pointer back to 0 so requester 1 wins over 3 again.
    do_reset(2);
    raise(1, 3'd4, 2'b10);
    raise(3, 3'd2, 2'b01);
    step();
    check("mid_gnt", bus.gnt, 4'b0010);
    step();
    do_reset(2);
    gnt_seen.delete();
    rec_en = 1'b1;
    run_until_quiet(30);
    rec_en = 1'b0;
    check("mid_first", seen(0), 1);
    check("mid_second", seen(1), 3);

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(299) == 0) do_reset(2);
      rand_inputs();
      step();
    end
    run_until_quiet(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
